mem_arbiter_ctrl: RTL

MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

---
 rtl/mem_arbiter_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Purpose : arbitrates D-cache and I-cache line requests onto one 128-bit backing store.
// Latency : response pulse LATENCY cycles after acceptance, then one dead DONE cycle.
// Backpr. : request levels are held by the caches; only one request is in flight.
//
// Ports:
//   clk, reset            - single clock, asynchronous active-low reset
//   reqD_mem / reqAddrD_mem / reqD_cache_write / data_to_mem
//                         - D-cache request level, line address, writeback flag, writeback data
//   data_from_mem / read_ready_from_mem / written_data_ack
//                         - D-cache fill line, fill-complete pulse, writeback-complete pulse
//   reqI_mem / reqAddrI_mem
//                         - I-cache fill request level and line address
//   data_to_icache / ready_to_icache
//                         - I-cache fill line and fill-complete pulse
//
// LATENCY must be 2..15 (4-bit counter); DEPTH_LOG2 must be below 26 so that
// the ignored upper address bits form a non-empty range.
module mem_arbiter_ctrl #(
  parameter int LATENCY    = 5,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         reset,

  input  logic         reqD_mem,
  input  logic [25:0]  reqAddrD_mem,
  input  logic         reqD_cache_write,
  input  logic [127:0] data_to_mem,
  output logic [127:0] data_from_mem,
  output logic         read_ready_from_mem,
  output logic         written_data_ack,

  input  logic         reqI_mem,
  input  logic [25:0]  reqAddrI_mem,
  output logic [127:0] data_to_icache,
  output logic         ready_to_icache
);

  localparam int         LINES  = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]            cnt_q;
  logic                  last_i_q;   // 1: the most recent grant went to the I port
  logic                  port_i_q;   // in-flight request came from the I port
  logic                  wr_q;       // in-flight request is a D writeback
  logic [DEPTH_LOG2-1:0] idx_q;      // line index of the in-flight request
  logic [127:0]          wdata_q;

  logic                  accept;
  logic                  grant_i;
  logic                  complete;

  // Backing store: deliberately outside the reset domain so contents survive reset.
  logic [127:0] mem [LINES];

  // Upper address bits alias onto the same lines; they are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{reqAddrD_mem[25:DEPTH_LOG2], reqAddrI_mem[25:DEPTH_LOG2]};

  // Next-state and grant decision.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    grant_i  = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (reqD_mem || reqI_mem) begin
          accept = 1'b1;
          // On contention, the port that did not win last time goes now.
          grant_i = reqI_mem && (!reqD_mem || !last_i_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register, request latch, counter and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q             <= IDLE;
      cnt_q               <= 4'd0;
      last_i_q            <= 1'b1;
      port_i_q            <= 1'b0;
      wr_q                <= 1'b0;
      idx_q               <= '0;
      wdata_q             <= '0;
      data_from_mem       <= '0;
      data_to_icache      <= '0;
      read_ready_from_mem <= 1'b0;
      written_data_ack    <= 1'b0;
      ready_to_icache     <= 1'b0;
    end else begin
      state_q <= state_d;

      // Pulses are one cycle wide: they only rise on the completing edge.
      read_ready_from_mem <= complete && !port_i_q && !wr_q;
      written_data_ack    <= complete && !port_i_q &&  wr_q;
      ready_to_icache     <= complete &&  port_i_q;

      if (accept) begin
        cnt_q    <= LAT_M1;
        port_i_q <= grant_i;
        last_i_q <= grant_i;
        wr_q     <= !grant_i && reqD_cache_write;
        idx_q    <= grant_i ? reqAddrI_mem[DEPTH_LOG2-1:0] : reqAddrD_mem[DEPTH_LOG2-1:0];
        wdata_q  <= data_to_mem;
      end else if (state_q == BUSY && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end

      // Fill data is only refreshed on a completion for its own port.
      if (complete && !wr_q) begin
        if (port_i_q) begin
          data_to_icache <= mem[idx_q];
        end else begin
          data_from_mem <= mem[idx_q];
        end
      end
    end
  end

  // Writeback lands on the completing edge; an in-flight write abandoned by
  // reset never reaches this point because state is forced back to IDLE.
  always_ff @(posedge clk) begin
    if (complete && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
